// File: rtl/gpu_alu_pkg.sv
// Shared constants, FSM state type and ALU request payload for the ALU sharing sequencer.
package gpu_alu_pkg;

    localparam logic [2:0]  FN_ADD    = 3'd0;
    localparam logic [2:0]  FN_SUB    = 3'd4;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned STEP_W    = 6;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]        func;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic              revsub;
        logic              dstdp31;
    } alu_op_t;

endpackage

// File: rtl/gpu_alu_arb.sv
// Per-cycle ALU ownership between pipeline and divider, with a divider starvation guard.
module gpu_alu_arb #(
    parameter int unsigned DIV_PRIO   = 0,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic div_active,
    input  logic pipe_req,
    output logic div_owner,
    output logic pipe_gnt
);

    localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve;
    logic                starved;

    assign starved   = (starve == STARVE_W'(STARVE_MAX));
    assign div_owner = div_active & ((DIV_PRIO != 0) | ~pipe_req | starved);
    assign pipe_gnt  = pipe_req & ~div_owner;

    // Counts consecutive cycles the busy divider lost the ALU.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            starve <= '0;
        end else if (!div_active || div_owner) begin
            starve <= '0;
        end else if (!starved) begin
            starve <= starve + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/gpu_alu_seq.sv
// Shares alu32 between one-cycle pipeline ops and a 32-step non-restoring unsigned divider.
module gpu_alu_seq
    import gpu_alu_pkg::*;
#(
    parameter int unsigned DIV_PRIO   = 0,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pipe_req,
    input  logic [2:0]  pipe_func,
    input  logic [31:0] pipe_a,
    input  logic [31:0] pipe_b,
    input  logic        pipe_cin,
    input  logic        pipe_revsub,
    input  logic        pipe_dstdp31,
    output logic        pipe_gnt,
    output logic [31:0] pipe_q,
    output logic        pipe_co,
    input  logic        div_start,
    input  logic        div_16,
    input  logic [31:0] div_dividend,
    input  logic [31:0] div_divisor,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_quot,
    output logic [31:0] div_rem,
    output logic [2:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic        alu_revsub,
    output logic        alu_dstdp31,
    input  logic [31:0] alu_q,
    input  logic        alu_co
);

    state_t            state, state_nxt;
    logic              s, s_nxt;
    logic [31:0]       r, r_nxt;
    logic [31:0]       q, q_nxt;
    logic [31:0]       d, d_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic [31:0]       quot_nxt, rem_nxt;
    logic              busy_nxt, done_nxt;
    logic              div_active, div_owner;
    alu_op_t           pipe_op, div_op, alu_op;

    assign div_active = (state == ITER) || (state == FIX);

    gpu_alu_arb #(
        .DIV_PRIO   (DIV_PRIO),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .div_active (div_active),
        .pipe_req   (pipe_req),
        .div_owner  (div_owner),
        .pipe_gnt   (pipe_gnt)
    );

    // Divider's ALU request: shift-and-add/subtract in ITER, remainder correction in FIX.
    always_comb begin
        div_op      = '0;
        div_op.func = FN_ADD;
        if (state == FIX) begin
            div_op.a = r;
            div_op.b = s ? d : '0;
        end else begin
            div_op.func = s ? FN_ADD : FN_SUB;
            div_op.a    = {r[30:0], q[31]};
            div_op.b    = d;
        end
    end

    assign pipe_op = '{func: pipe_func, a: pipe_a, b: pipe_b, cin: pipe_cin,
                       revsub: pipe_revsub, dstdp31: pipe_dstdp31};
    assign alu_op  = div_owner ? div_op : pipe_op;

    assign alu_func    = alu_op.func;
    assign alu_a       = alu_op.a;
    assign alu_b       = alu_op.b;
    assign alu_cin     = alu_op.cin;
    assign alu_revsub  = alu_op.revsub;
    assign alu_dstdp31 = alu_op.dstdp31;
    assign pipe_q      = alu_q;
    assign pipe_co     = alu_co;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            s        <= 1'b0;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            step     <= '0;
            div_quot <= '0;
            div_rem  <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            s        <= s_nxt;
            r        <= r_nxt;
            q        <= q_nxt;
            d        <= d_nxt;
            step     <= step_nxt;
            div_quot <= quot_nxt;
            div_rem  <= rem_nxt;
            div_busy <= busy_nxt;
            div_done <= done_nxt;
        end
    end

    // Next state; divider registers only advance on cycles the divider owns the ALU.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        r_nxt     = r;
        q_nxt     = q;
        d_nxt     = d;
        step_nxt  = step;
        quot_nxt  = div_quot;
        rem_nxt   = div_rem;
        case (state)
            IDLE: begin
                if (div_start) begin
                    d_nxt     = div_divisor;
                    s_nxt     = 1'b0;
                    step_nxt  = '0;
                    state_nxt = ITER;
                    if (div_16) begin
                        r_nxt = {16'b0, div_dividend[31:16]};
                        q_nxt = {div_dividend[15:0], 16'b0};
                    end else begin
                        r_nxt = '0;
                        q_nxt = div_dividend;
                    end
                end
            end
            ITER: begin
                if (div_owner) begin
                    s_nxt    = s ^ alu_co;
                    r_nxt    = alu_q;
                    q_nxt    = {q[30:0], ~s_nxt};
                    step_nxt = step + STEP_W'(1);
                    if (step == STEP_W'(DIV_STEPS - 1)) begin
                        state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                if (div_owner) begin
                    quot_nxt  = q;
                    rem_nxt   = alu_q;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == ITER) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_gpu_alu_seq.sv
// Self-checking bench: DIV_PRIO=0 and DIV_PRIO=1 instances against a cycle-level behavioural model.
module tb_gpu_alu_seq;

    localparam int SMAX = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pipe_req;
    logic [2:0]  pipe_func;
    logic [31:0] pipe_a, pipe_b;
    logic        pipe_cin, pipe_revsub, pipe_dstdp31;
    logic        div_start, div_16;
    logic [31:0] div_dividend, div_divisor;

    logic [1:0]       gnt, pco, busy, done, acin, arev, adst, aco;
    logic [1:0][31:0] pq, quot, rem, aa, ab, aq;
    logic [1:0][2:0]  af;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          phase[2];
    int          work[2];
    int          starve[2];
    int          done_cyc[2];
    logic [31:0] ma[2], md[2], mq[2], mr[2];
    logic        m16[2];

    always #5 sys_clk = ~sys_clk;

    // Stand-in for alu32: ADD with carry out, SUB with borrow out, others bitwise.
    function automatic logic [32:0] alu_fn(input logic [2:0] f, input logic [31:0] a, b,
                                           input logic cin, rev, dst);
        logic [32:0] x;
        case (f)
            3'd0: x = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            3'd4: x = rev ? ({1'b0, b} - {1'b0, a} - {32'b0, cin})
                          : ({1'b0, a} - {1'b0, b} - {32'b0, cin});
            3'd1: x = {1'b0, a & b};
            3'd2: x = {1'b0, a | b};
            default: x = {dst, a ^ b};
        endcase
        return x;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_alu
        assign {aco[g], aq[g]} = alu_fn(af[g], aa[g], ab[g], acin[g], arev[g], adst[g]);
    end

    gpu_alu_seq #(.DIV_PRIO(0), .STARVE_MAX(SMAX)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pipe_req(pipe_req), .pipe_func(pipe_func),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_cin(pipe_cin), .pipe_revsub(pipe_revsub),
        .pipe_dstdp31(pipe_dstdp31), .pipe_gnt(gnt[0]), .pipe_q(pq[0]), .pipe_co(pco[0]),
        .div_start(div_start), .div_16(div_16), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_busy(busy[0]), .div_done(done[0]),
        .div_quot(quot[0]), .div_rem(rem[0]), .alu_func(af[0]), .alu_a(aa[0]), .alu_b(ab[0]),
        .alu_cin(acin[0]), .alu_revsub(arev[0]), .alu_dstdp31(adst[0]),
        .alu_q(aq[0]), .alu_co(aco[0]));

    gpu_alu_seq #(.DIV_PRIO(1), .STARVE_MAX(SMAX)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pipe_req(pipe_req), .pipe_func(pipe_func),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_cin(pipe_cin), .pipe_revsub(pipe_revsub),
        .pipe_dstdp31(pipe_dstdp31), .pipe_gnt(gnt[1]), .pipe_q(pq[1]), .pipe_co(pco[1]),
        .div_start(div_start), .div_16(div_16), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_busy(busy[1]), .div_done(done[1]),
        .div_quot(quot[1]), .div_rem(rem[1]), .alu_func(af[1]), .alu_a(aa[1]), .alu_b(ab[1]),
        .alu_cin(acin[1]), .alu_revsub(arev[1]), .alu_dstdp31(adst[1]),
        .alu_q(aq[1]), .alu_co(aco[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain integer division.
    function automatic void exp_div(input logic [31:0] a, d, input logic mode16,
                                    output logic [31:0] qo, ro);
        logic [63:0] n;
        n = mode16 ? {16'b0, a, 16'b0} : {32'b0, a};
        if (d == 0) begin
            qo = '1;
            ro = a;
        end else begin
            qo = 32'(n / {32'b0, d});
            ro = 32'(n % {32'b0, d});
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; work[i] = 0; starve[i] = 0;
            mq[i] = '0; mr[i] = '0; ma[i] = '0; md[i] = '0; m16[i] = 1'b0;
        end
    endtask

    // One cycle: compare DUT against the model, advance the model, move to the next negedge.
    task automatic cycle();
        logic        owner;
        logic [31:0] eq, er, x0;
        #1;
        for (int i = 0; i < 2; i++) begin
            owner = (phase[i] == 1) && (i == 1 || !pipe_req || starve[i] == SMAX);
            chk("busy", 64'(busy[i]), 64'(phase[i] == 1));
            chk("done", 64'(done[i]), 64'(phase[i] == 2));
            chk("quot", 64'(quot[i]), 64'(mq[i]));
            chk("rem",  64'(rem[i]),  64'(mr[i]));
            chk("pipe_gnt", 64'(gnt[i]), 64'(pipe_req && !owner));
            if (!owner) begin
                chk("alu_ops", {aa[i], ab[i]}, {pipe_a, pipe_b});
                chk("alu_ctl", 64'({af[i], acin[i], arev[i], adst[i]}),
                    64'({pipe_func, pipe_cin, pipe_revsub, pipe_dstdp31}));
                chk("pipe_q", 64'({pco[i], pq[i]}),
                    64'(alu_fn(pipe_func, pipe_a, pipe_b, pipe_cin, pipe_revsub, pipe_dstdp31)));
            end else if (work[i] < 32) begin
                chk("iter_b", 64'(ab[i]), 64'(md[i]));
                chk("iter_ctl", 64'({acin[i], arev[i], adst[i]}), 64'(0));
                chk("iter_fn", 64'(af[i] == 3'd0 || af[i] == 3'd4), 64'(1));
                if (work[i] == 0) begin
                    x0 = m16[i] ? {15'b0, ma[i][31:16], ma[i][15]} : {31'b0, ma[i][31]};
                    chk("iter0_fn", 64'(af[i]), 64'(4));
                    chk("iter0_a", 64'(aa[i]), 64'(x0));
                end
            end else begin
                exp_div(ma[i], md[i], m16[i], eq, er);
                chk("fix_fn", 64'(af[i]), 64'(0));
                chk("fix_b", 64'(ab[i] == 0 || ab[i] == md[i]), 64'(1));
                chk("fix_sum", 64'(32'(aa[i] + ab[i])), 64'(er));
            end
            if (done[i] && done_cyc[i] < 0) done_cyc[i] = cyc;

            if (sys_rst) begin
                phase[i] = 0; work[i] = 0; starve[i] = 0; mq[i] = '0; mr[i] = '0;
            end else begin
                case (phase[i])
                    0: begin
                        starve[i] = 0;
                        if (div_start) begin
                            phase[i] = 1; work[i] = 0;
                            ma[i] = div_dividend; md[i] = div_divisor; m16[i] = div_16;
                        end
                    end
                    1: begin
                        if (owner) begin
                            starve[i] = 0;
                            if (work[i] == 32) begin
                                exp_div(ma[i], md[i], m16[i], mq[i], mr[i]);
                                phase[i] = 2;
                            end
                            work[i]++;
                        end else if (starve[i] < SMAX) begin
                            starve[i]++;
                        end
                    end
                    default: begin
                        phase[i] = 0; starve[i] = 0;
                    end
                endcase
            end
        end
        cyc++;
        @(negedge sys_clk);
    endtask

    task automatic rand_pipe();
        pipe_func = 3'($urandom); pipe_a = $urandom; pipe_b = $urandom;
        pipe_cin = 1'($urandom); pipe_revsub = 1'($urandom); pipe_dstdp31 = 1'($urandom);
    endtask

    task automatic run_div(input logic [31:0] a, d, input logic mode16, input logic req_on,
                           input logic restart10, input int rst_at, input int max_n,
                           input logic [31:0] eq, er, input int lat0, lat1);
        int t0;
        int lat[2];
        done_cyc[0] = -1; done_cyc[1] = -1;
        t0 = cyc;
        lat[0] = lat0; lat[1] = lat1;
        for (int n = 0; n < max_n; n++) begin
            div_start = (n == 0) || (restart10 && n == 10);
            if (n == 0) begin
                div_dividend = a; div_divisor = d; div_16 = mode16;
            end else begin
                div_dividend = $urandom; div_divisor = $urandom; div_16 = 1'($urandom);
            end
            sys_rst  = (n == rst_at);
            pipe_req = req_on;
            rand_pipe();
            cycle();
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
        end
        sys_rst = 1'b0; div_start = 1'b0; pipe_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (lat[i] < 0) begin
                chk("no_done", 64'(done_cyc[i] < 0), 64'(1));
            end else begin
                chk("latency", 64'(done_cyc[i] - t0), 64'(lat[i]));
            end
            chk("lit_quot", 64'(quot[i]), 64'(eq));
            chk("lit_rem",  64'(rem[i]),  64'(er));
        end
        cycle();
        cycle();
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic        r16;
        int          req_pct;
        sys_rst = 1'b1; pipe_req = 1'b0; div_start = 1'b0; div_16 = 1'b0;
        div_dividend = '0; div_divisor = '0;
        rand_pipe();
        model_reset();
        done_cyc[0] = -1; done_cyc[1] = -1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        cycle();
        sys_rst = 1'b0;
        cycle();

        run_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, -1, 400, 32'd14, 32'd2, 34, 34);
        run_div(32'h0003_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b0, -1, 400,
                32'h0001_8000, 32'd0, 34, 34);
        run_div(32'd1000, 32'd3, 1'b0, 1'b1, 1'b0, -1, 400, 32'd333, 32'd1, 34 + 33 * 8, 34);
        run_div(32'd5, 32'd0, 1'b0, 1'b0, 1'b1, -1, 400, 32'hFFFF_FFFF, 32'd5, 34, 34);
        run_div(32'd12345, 32'd67, 1'b0, 1'b0, 1'b0, 20, 30, 32'd0, 32'd0, -1, -1);
        run_div(32'd12345, 32'd67, 1'b0, 1'b0, 1'b0, -1, 400, 32'd184, 32'd17, 34, 34);

        req_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) req_pct = int'($urandom_range(0, 100));
            pipe_req  = (int'($urandom_range(0, 99)) < req_pct);
            div_start = ($urandom_range(0, 7) == 0);
            sys_rst   = ($urandom_range(0, 499) == 0);
            r16 = 1'($urandom);
            if (!r16 && $urandom_range(0, 5) == 0) rd = 32'd0;
            else if ($urandom_range(0, 1) == 0) rd = $urandom_range(1, 1000);
            else rd = $urandom_range(1, 32'h7FFF_FFFF);
            ra = $urandom;
            if (r16) ra[31:16] = 16'($urandom_range(0, (rd > 32'd65535) ? 32'd65535 : rd - 32'd1));
            div_dividend = ra; div_divisor = rd; div_16 = r16;
            rand_pipe();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
